// File: rtl/tx_link_pkg.sv
// Shared encodings for the JESD204B TX link layer: sequencer states and
// the stream-select values understood by the link-layer multiplexer.
package tx_link_pkg;

   typedef enum logic [1:0] {
      ST_CGS      = 2'd0,
      ST_ILA_WAIT = 2'd1,
      ST_ILA      = 2'd2,
      ST_DATA     = 2'd3
   } link_state_e;

   localparam logic [2:0] LINK_MUX_USER = 3'd0;
   localparam logic [2:0] LINK_MUX_KSEQ = 3'd1;
   localparam logic [2:0] LINK_MUX_ILA  = 3'd2;

   localparam int FRAME_IDX_W = 5;

endpackage

// File: rtl/lmfc_counter.sv
// Free-running octet-in-multiframe counter; the LMFC edge marks octet 0
// and frame_idx is the frame the current octet belongs to.
module lmfc_counter
   import tx_link_pkg::*;
#(
   parameter int F      = 1,
   parameter int K      = 32,
   parameter int LMFC_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic [LMFC_W-1:0]      o_lmfc_cnt,
   output logic [FRAME_IDX_W-1:0] o_frame_idx,
   output logic                   o_lmfc_edge
);

   localparam int FK = F * K;

   logic [LMFC_W-1:0] lmfc_cnt_d, lmfc_cnt_q;
   logic              lmfc_edge_d, lmfc_edge_q;

   always_comb begin
      lmfc_cnt_d  = (lmfc_cnt_q == LMFC_W'(FK - 1)) ? '0 : lmfc_cnt_q + LMFC_W'(1);
      lmfc_edge_d = (lmfc_cnt_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lmfc_cnt_q  <= '0;
         lmfc_edge_q <= 1'b1;
      end else begin
         lmfc_cnt_q  <= lmfc_cnt_d;
         lmfc_edge_q <= lmfc_edge_d;
      end
   end

   assign o_lmfc_cnt  = lmfc_cnt_q;
   assign o_lmfc_edge = lmfc_edge_q;
   assign o_frame_idx = FRAME_IDX_W'(lmfc_cnt_q / LMFC_W'(F));

endmodule

// File: rtl/tx_link_ctrl.sv
// TX link sequencer: CGS -> ILA_WAIT -> ILA -> DATA with SYNC~ monitoring,
// re-sync on a long SYNC~-low run and an error pulse on short ones.
module tx_link_ctrl
   import tx_link_pkg::*;
#(
   parameter int F          = 1,
   parameter int K          = 32,
   parameter int ILA_MF     = 4,
   parameter int RESYNC_LEN = 14,
   parameter int LMFC_W     = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_sync_n,
   output logic [2:0]             o_link_mux,
   output logic [FRAME_IDX_W-1:0] o_no_frame_de_assertion,
   output logic                   o_lmfc_edge,
   output logic [1:0]             o_ila_mf,
   output logic [LMFC_W-1:0]      o_ila_octet,
   output logic                   o_user_ready,
   output logic                   o_err_report,
   output logic [1:0]             o_state
);

   localparam int FK    = F * K;
   localparam int LOW_W = $clog2(RESYNC_LEN + 1);

   logic [LMFC_W-1:0]      lmfc_cnt;
   logic [FRAME_IDX_W-1:0] frame_idx;
   logic                   lmfc_last;
   logic [LMFC_W-1:0]      lmfc_next;

   link_state_e            state_d, state_q;
   logic [2:0]             link_mux_d, link_mux_q;
   logic [FRAME_IDX_W-1:0] no_frame_d, no_frame_q;
   logic [1:0]             ila_mf_d, ila_mf_q;
   logic [LMFC_W-1:0]      ila_octet_d, ila_octet_q;
   logic                   user_ready_d, user_ready_q;
   logic                   err_d, err_q;
   logic [LOW_W-1:0]       low_cnt_d, low_cnt_q;

   lmfc_counter #(
      .F      (F),
      .K      (K),
      .LMFC_W (LMFC_W)
   ) u_lmfc (
      .clk         (clk),
      .rst         (rst),
      .o_lmfc_cnt  (lmfc_cnt),
      .o_frame_idx (frame_idx),
      .o_lmfc_edge (o_lmfc_edge)
   );

   assign lmfc_last = (lmfc_cnt == LMFC_W'(FK - 1));
   assign lmfc_next = lmfc_last ? '0 : lmfc_cnt + LMFC_W'(1);

   always_comb begin
      state_d    = state_q;
      no_frame_d = no_frame_q;
      ila_mf_d   = ila_mf_q;
      low_cnt_d  = low_cnt_q;
      err_d      = 1'b0;

      case (state_q)
         ST_CGS: begin
            low_cnt_d = '0;
            if (i_sync_n) begin
               state_d    = ST_ILA_WAIT;
               no_frame_d = frame_idx;
            end
         end
         ST_ILA_WAIT: begin
            low_cnt_d = '0;
            if (!i_sync_n) begin
               state_d = ST_CGS;
            end else if (lmfc_last) begin
               state_d = ST_ILA;
            end
         end
         ST_ILA, ST_DATA: begin
            if (state_q == ST_ILA && lmfc_last) begin
               if (ila_mf_q == 2'(ILA_MF - 1)) begin
                  state_d  = ST_DATA;
                  ila_mf_d = '0;
               end else begin
                  ila_mf_d = ila_mf_q + 2'd1;
               end
            end
            // SYNC~ monitor is evaluated last so a re-sync overrides any ILA advance
            if (!i_sync_n) begin
               if (low_cnt_q >= LOW_W'(RESYNC_LEN - 1)) begin
                  state_d   = ST_CGS;
                  ila_mf_d  = '0;
                  low_cnt_d = '0;
               end else begin
                  low_cnt_d = low_cnt_q + LOW_W'(1);
               end
            end else begin
               err_d     = (low_cnt_q != '0);
               low_cnt_d = '0;
            end
         end
         default: state_d = ST_CGS;
      endcase

      link_mux_d   = LINK_MUX_KSEQ;
      user_ready_d = 1'b0;
      ila_octet_d  = '0;
      if (state_d == ST_ILA) begin
         link_mux_d  = LINK_MUX_ILA;
         ila_octet_d = lmfc_next;
      end else if (state_d == ST_DATA) begin
         link_mux_d   = LINK_MUX_USER;
         user_ready_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_CGS;
         link_mux_q   <= LINK_MUX_KSEQ;
         no_frame_q   <= '0;
         ila_mf_q     <= '0;
         ila_octet_q  <= '0;
         user_ready_q <= 1'b0;
         err_q        <= 1'b0;
         low_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         link_mux_q   <= link_mux_d;
         no_frame_q   <= no_frame_d;
         ila_mf_q     <= ila_mf_d;
         ila_octet_q  <= ila_octet_d;
         user_ready_q <= user_ready_d;
         err_q        <= err_d;
         low_cnt_q    <= low_cnt_d;
      end
   end

   assign o_state                 = state_q;
   assign o_link_mux              = link_mux_q;
   assign o_no_frame_de_assertion = no_frame_q;
   assign o_ila_mf                = ila_mf_q;
   assign o_ila_octet             = ila_octet_q;
   assign o_user_ready            = user_ready_q;
   assign o_err_report            = err_q;

endmodule

// File: tb/tb_tx_link_ctrl.sv
// Bench for tx_link_ctrl: a timestamp-based model checked every cycle on the
// F=1/K=32 instance, plus literal checks on both it and an F=2/K=16 instance.
module tb_tx_link_ctrl;

   localparam int F1 = 1;
   localparam int K1 = 32;
   localparam int FK1 = F1 * K1;
   localparam int ILA_MF1 = 4;
   localparam int RESYNC1 = 14;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, sync_n, rst2, sync2;
   logic [2:0] link_mux, link_mux2;
   logic [4:0] nframe, nframe2;
   logic       lmfc_edge, lmfc_edge2;
   logic [1:0] ila_mf, ila_mf2;
   logic [7:0] ila_octet, ila_octet2;
   logic       user_ready, user_ready2;
   logic       err_report, err_report2;
   logic [1:0] state, state2;

   int checks = 0;
   int errors = 0;
   int fail_prints = 0;
   int cyc = 0;
   int cyc2 = 0;
   logic check_en = 1'b0;

   tx_link_ctrl #(.F(F1), .K(K1), .ILA_MF(ILA_MF1), .RESYNC_LEN(RESYNC1), .LMFC_W(8)) dut (
      .clk(clk), .rst(rst), .i_sync_n(sync_n),
      .o_link_mux(link_mux), .o_no_frame_de_assertion(nframe), .o_lmfc_edge(lmfc_edge),
      .o_ila_mf(ila_mf), .o_ila_octet(ila_octet), .o_user_ready(user_ready),
      .o_err_report(err_report), .o_state(state)
   );

   tx_link_ctrl #(.F(2), .K(16), .ILA_MF(4), .RESYNC_LEN(19), .LMFC_W(8)) dut2 (
      .clk(clk), .rst(rst2), .i_sync_n(sync2),
      .o_link_mux(link_mux2), .o_no_frame_de_assertion(nframe2), .o_lmfc_edge(lmfc_edge2),
      .o_ila_mf(ila_mf2), .o_ila_octet(ila_octet2), .o_user_ready(user_ready2),
      .o_err_report(err_report2), .o_state(state2)
   );

   always @(posedge clk) cyc  <= rst  ? 0 : cyc + 1;
   always @(posedge clk) cyc2 <= rst2 ? 0 : cyc2 + 1;

   // Model: t counts cycles since reset, ila_t counts cycles spent in ILA
   typedef struct packed {
      int t;
      int mode;
      int ila_t;
      int lows;
      int nframe;
      int err;
   } model_t;

   model_t m;

   function automatic model_t model_step(model_t cur, logic r, logic s);
      model_t n;
      int lmfc;
      n = cur;
      if (r) begin
         n = '0;
         return n;
      end
      lmfc  = cur.t % FK1;
      n.t   = cur.t + 1;
      n.err = 0;
      case (cur.mode)
         0: if (s) begin
            n.mode   = 1;
            n.nframe = lmfc / F1;
         end
         1: if (!s) n.mode = 0;
            else if (lmfc == FK1 - 1) begin
               n.mode  = 2;
               n.ila_t = 0;
            end
         default: begin
            if (cur.mode == 2) begin
               n.ila_t = cur.ila_t + 1;
               if (n.ila_t == ILA_MF1 * FK1) n.mode = 3;
            end
            if (!s) begin
               n.lows = cur.lows + 1;
               if (n.lows == RESYNC1) begin
                  n.mode = 0;
                  n.lows = 0;
               end
            end else begin
               if (cur.lows > 0) n.err = 1;
               n.lows = 0;
            end
         end
      endcase
      return n;
   endfunction

   always @(posedge clk) m <= model_step(m, rst, sync_n);

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         if (fail_prints < 40) begin
            fail_prints++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
         end
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         checkOutput("m_state", state, m.mode);
         checkOutput("m_mux", link_mux, (m.mode == 2) ? 2 : (m.mode == 3) ? 0 : 1);
         checkOutput("m_ready", user_ready, (m.mode == 3) ? 1 : 0);
         checkOutput("m_err", err_report, m.err);
         checkOutput("m_edge", lmfc_edge, (m.t % FK1 == 0) ? 1 : 0);
         checkOutput("m_ila_mf", ila_mf, (m.mode == 2) ? m.ila_t / FK1 : 0);
         checkOutput("m_ila_octet", ila_octet, (m.mode == 2) ? m.ila_t % FK1 : 0);
         checkOutput("m_nframe", nframe, m.nframe);
      end
   end

   task automatic waitCycle(input int sel, input int target);
      int guard = 0;
      while (((sel == 0) ? cyc : cyc2) != target && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 2000) checkOutput("wait_timeout", (sel == 0) ? cyc : cyc2, target);
   endtask

   task automatic applyStimulus(input int sel, input int at_cycle, input logic r, input logic s);
      waitCycle(sel, at_cycle);
      if (sel == 0) begin
         rst = r;
         sync_n = s;
      end else begin
         rst2 = r;
         sync2 = s;
      end
   endtask

   initial begin
      rst = 1'b1; sync_n = 1'b0; rst2 = 1'b1; sync2 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_en = 1'b1;
      checkOutput("rst_state", state, 0);
      checkOutput("rst_mux", link_mux, 1);
      checkOutput("rst_edge", lmfc_edge, 1);
      checkOutput("rst_ready", user_ready, 0);

      waitCycle(0, 1);   checkOutput("edge_c1", lmfc_edge, 0);
      waitCycle(0, 32);  checkOutput("edge_c32", lmfc_edge, 1);
      waitCycle(0, 50);  checkOutput("cgs_mux", link_mux, 1);
      applyStimulus(0, 70, 1'b0, 1'b1);
      waitCycle(0, 71);  checkOutput("wait_state", state, 1);
                         checkOutput("nframe_6", nframe, 6);
      waitCycle(0, 95);  checkOutput("mux_c95", link_mux, 1);
      waitCycle(0, 96);  checkOutput("mux_c96", link_mux, 2);
                         checkOutput("ila_mf_c96", ila_mf, 0);
      waitCycle(0, 128); checkOutput("ila_mf_c128", ila_mf, 1);
      waitCycle(0, 192); checkOutput("ila_mf_c192", ila_mf, 3);
      waitCycle(0, 223); checkOutput("octet_c223", ila_octet, 31);
                         checkOutput("mux_c223", link_mux, 2);
      waitCycle(0, 224); checkOutput("mux_c224", link_mux, 0);
                         checkOutput("ready_c224", user_ready, 1);

      // Short SYNC~ pulse in DATA
      applyStimulus(0, 240, 1'b0, 1'b0);
      applyStimulus(0, 245, 1'b0, 1'b1);
      checkOutput("err_c245", err_report, 0);
      waitCycle(0, 246); checkOutput("err_c246", err_report, 1);
                         checkOutput("mux_c246", link_mux, 0);
      waitCycle(0, 247); checkOutput("err_c247", err_report, 0);

      // Long SYNC~ low forces re-sync, then a full ILA again
      applyStimulus(0, 260, 1'b0, 1'b0);
      waitCycle(0, 273); checkOutput("state_c273", state, 3);
      waitCycle(0, 274); checkOutput("state_c274", state, 0);
                         checkOutput("mux_c274", link_mux, 1);
                         checkOutput("ready_c274", user_ready, 0);
      applyStimulus(0, 300, 1'b0, 1'b1);
      waitCycle(0, 301); checkOutput("nframe_12", nframe, 12);
      waitCycle(0, 319); checkOutput("mux_c319", link_mux, 1);
      waitCycle(0, 320); checkOutput("mux_c320", link_mux, 2);
      waitCycle(0, 447); checkOutput("mux_c447", link_mux, 2);
      waitCycle(0, 448); checkOutput("mux_c448", link_mux, 0);

      // SYNC~ low during ILA_WAIT
      applyStimulus(0, 460, 1'b0, 1'b0);
      waitCycle(0, 474); checkOutput("state_c474", state, 0);
      applyStimulus(0, 480, 1'b0, 1'b1);
      waitCycle(0, 481); checkOutput("state_c481", state, 1);
      applyStimulus(0, 485, 1'b0, 1'b0);
      waitCycle(0, 486); checkOutput("state_c486", state, 0);
      applyStimulus(0, 490, 1'b0, 1'b1);
      waitCycle(0, 511); checkOutput("state_c511", state, 1);
      waitCycle(0, 512); checkOutput("state_c512", state, 2);

      // Reset in the middle of ILA
      applyStimulus(0, 520, 1'b1, 1'b1);
      checkOutput("octet_c520", ila_octet, 8);
      @(negedge clk);
      rst = 1'b0;
      sync_n = 1'b0;
      checkOutput("mrst_state", state, 0);
      checkOutput("mrst_mux", link_mux, 1);
      checkOutput("mrst_edge", lmfc_edge, 1);
      checkOutput("mrst_ila_mf", ila_mf, 0);
      checkOutput("mrst_octet", ila_octet, 0);
      checkOutput("mrst_ready", user_ready, 0);
      checkOutput("mrst_nframe", nframe, 0);
      checkOutput("mrst_err", err_report, 0);

      // De-assertion on the last octet of a multiframe waits a full multiframe
      applyStimulus(0, 31, 1'b0, 1'b1);
      waitCycle(0, 32);  checkOutput("nframe_31", nframe, 31);
      waitCycle(0, 63);  checkOutput("mux_late_c63", link_mux, 1);
      waitCycle(0, 64);  checkOutput("mux_late_c64", link_mux, 2);
      applyStimulus(0, 70, 1'b0, 1'b0);
      applyStimulus(0, 73, 1'b0, 1'b1);
      waitCycle(0, 74);  checkOutput("ila_err_c74", err_report, 1);
                         checkOutput("ila_state_c74", state, 2);
      waitCycle(0, 192); checkOutput("mux_late_c192", link_mux, 0);

      // F=2, K=16 instance
      @(negedge clk);
      rst2 = 1'b0;
      checkOutput("f2_rst_state", state2, 0);
      checkOutput("f2_rst_edge", lmfc_edge2, 1);
      applyStimulus(1, 13, 1'b0, 1'b1);
      waitCycle(1, 14);  checkOutput("f2_state", state2, 1);
                         checkOutput("f2_nframe", nframe2, 6);
      waitCycle(1, 31);  checkOutput("f2_mux_c31", link_mux2, 1);
      waitCycle(1, 32);  checkOutput("f2_mux_c32", link_mux2, 2);
                         checkOutput("f2_octet_c32", ila_octet2, 0);
                         checkOutput("f2_edge_c32", lmfc_edge2, 1);
      waitCycle(1, 33);  checkOutput("f2_octet_c33", ila_octet2, 1);
      waitCycle(1, 64);  checkOutput("f2_ila_mf_c64", ila_mf2, 1);
      waitCycle(1, 159); checkOutput("f2_mux_c159", link_mux2, 2);
                         checkOutput("f2_ila_mf_c159", ila_mf2, 3);
                         checkOutput("f2_octet_c159", ila_octet2, 31);
      waitCycle(1, 160); checkOutput("f2_mux_c160", link_mux2, 0);
                         checkOutput("f2_ready_c160", user_ready2, 1);
                         checkOutput("f2_err_c160", err_report2, 0);

      check_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tx_link_ctrl.md
Name: tx_link_ctrl

Overview:
Sequencer for the JESD204B TX link layer. Owns the LMFC/frame counters, watches SYNC~, and drives the link-layer stream select through the sequence CGS (continuous K) -> ILA -> user data, including re-sync on SYNC~ re-assertion. It supplies the frame-position value for SYNC~ de-assertion and the ILA position used by the ILA generator.

Parameters:
F, 1, octets per frame (1..8)
K, 32, frames per multiframe (1..32)
ILA_MF, 4, multiframes in ILA sequence (1..4)
RESYNC_LEN, 14, consecutive SYNC~-low cycles that force re-sync (5*F+9)
LMFC_W, 8, width of octet-in-multiframe counter (>= clog2(F*K))

Ports:
clk  in  1  character clock
rst  in  1  synchronous reset, active-high
i_sync_n  in  1  SYNC~ from receiver, already synchronized to clk, low = request sync
o_link_mux  out  3  stream select to link layer: 0 user, 1 continuous K, 2 ILA
o_no_frame_de_assertion  out  5  frame index within multiframe captured at SYNC~ de-assertion
o_lmfc_edge  out  1  high while lmfc_cnt==0
o_ila_mf  out  2  current ILA multiframe index
o_ila_octet  out  LMFC_W  octet index within current ILA multiframe
o_user_ready  out  1  high in DATA; transport may present user data
o_err_report  out  1  one-cycle pulse on short SYNC~-low pulse
o_state  out  2  0 CGS, 1 ILA_WAIT, 2 ILA, 3 DATA

Behaviour:
- Reset (rst high at edge): state=CGS, lmfc_cnt=0, o_link_mux=1, o_no_frame_de_assertion=0, o_ila_mf=0, o_ila_octet=0, o_user_ready=0, o_err_report=0, low_cnt=0, o_lmfc_edge=1 (follows lmfc_cnt). Reset mid-operation aborts any sequence identically.
- lmfc_cnt: increments every cycle, 0..F*K-1, wraps to 0. frame_idx = lmfc_cnt / F.
- All outputs registered; o_link_mux, o_user_ready and o_state change on the same edge as state.
- CGS: mux=1. Sampled i_sync_n==1 -> next ILA_WAIT; o_no_frame_de_assertion <= frame_idx of the sampling cycle.
- ILA_WAIT: mux=1. Sampled i_sync_n==0 -> CGS next cycle. Else at the edge where lmfc_cnt==F*K-1 -> ILA, so ILA's first cycle has lmfc_cnt==0. De-assertion in the cycle with lmfc_cnt==F*K-1 still waits a full multiframe, since the transition to ILA_WAIT takes that edge.
- ILA: mux=2, o_ila_octet=lmfc_cnt, o_ila_mf increments on each wrap. At the edge ending multiframe ILA_MF-1 -> DATA; o_ila_mf resets to 0. Total ILA length is exactly ILA_MF*F*K cycles.
- DATA: mux=0, o_user_ready=1. Remains in DATA indefinitely absent re-sync.
- SYNC~ monitoring in ILA and DATA:
  - low_cnt counts consecutive i_sync_n==0 samples and saturates at RESYNC_LEN.
  - On the RESYNC_LEN-th consecutive low sample, go to CGS next cycle (mux=1, user_ready=0, low_cnt=0).
  - If i_sync_n==1 is sampled with low_cnt in 1..RESYNC_LEN-1, o_err_report=1 for exactly the next cycle, state unchanged, low_cnt=0.
  - low_cnt is cleared on every entry to CGS.
- Any ILA_MF wrap or lmfc wrap coinciding with a re-sync trigger: the re-sync wins.

Decomposition:
- Package tx_link_pkg: state encoding (CGS/ILA_WAIT/ILA/DATA) and link-mux constants LINK_MUX_USER=0, LINK_MUX_KSEQ=1, LINK_MUX_ILA=2, shared with the link layer.
- Sub-module: lmfc_counter (params F, K, LMFC_W). Outputs lmfc_cnt, frame_idx and lmfc_edge; synchronous reset.
- FSM and SYNC~ monitor stay in tx_link_ctrl.

Test Plan:
- F=1, K=32: rst then i_sync_n=0 for 100 cycles -> o_link_mux=1 throughout; o_lmfc_edge high at cycles 0, 32, 64, 96; o_state=0.
- i_sync_n rises at cycle 70 (lmfc_cnt=6) -> o_no_frame_de_assertion=6, o_state=1 from cycle 71. o_link_mux=2 from cycle 96 to 223, with o_ila_mf stepping 0,1,2,3 at 96/128/160/192. o_link_mux=0 and o_user_ready=1 from cycle 224.
- F=2, K=16: i_sync_n rises at lmfc_cnt=13 -> o_no_frame_de_assertion=6; ILA starts at next lmfc_cnt==0 and lasts 128 cycles.
- In DATA: i_sync_n low 5 cycles then high -> o_err_report exactly one cycle after the high sample; o_link_mux stays 0.
- In DATA: i_sync_n low 14 cycles -> o_link_mux=1, o_state=0 on the cycle after the 14th low sample. On release, the controller waits for the LMFC edge and repeats a full ILA.
- i_sync_n low during ILA_WAIT -> CGS next cycle. Separately, rst asserted mid-ILA -> all outputs at reset values and lmfc_cnt=0 on the next cycle.
